// File: rtl/sp_ram_burst_reader.sv
// Burst read initiator for a single-port RAM: issues one word read per cycle and
// streams the returned words through a two-entry buffer onto a valid/ready port.
module sp_ram_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]      cmd_len_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic                      out_last_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic                    inflight_q, inflight_d;
  logic                    zero_done_q, zero_done_d;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic [DATA_WIDTH-1:0]   buf_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;

  logic                    cmd_fire_s;
  logic                    pop_s;
  logic                    issue_s;
  logic                    last_beat_s;
  logic [2:0]              occ_s;

  // Occupancy counts buffered words plus the read in flight, net of this cycle's pop.
  assign out_valid_o = (cnt_q != 2'd0);
  assign pop_s       = out_valid_o & out_ready_i;
  assign last_beat_s = out_valid_o & (beat_q == (len_q - LEN_ONE));
  assign occ_s       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;
  assign out_data_o  = buf_q[rd_ptr_q];
  assign out_last_o  = last_beat_s;
  assign ram_we_o    = 1'b0;
  assign ram_be_o    = {BYTES{1'b1}};
  assign ram_wdata_o = {DATA_WIDTH{1'b0}};

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire_s && (cmd_len_i != LEN_ZERO)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (issue_s && (rem_q == LEN_ONE)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (pop_s && last_beat_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-state outputs; a zero-length command is completed while staying idle.
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    issue_s     = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = ~zero_done_q;
        busy_o      = zero_done_q;
        done_o      = zero_done_q;
      end
      S_RUN: begin
        busy_o  = 1'b1;
        issue_s = (rem_q != LEN_ZERO) && (occ_s < 3'd2);
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        done_o = pop_s & last_beat_s;
      end
      default: begin
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        issue_s     = 1'b0;
        done_o      = 1'b0;
      end
    endcase
    ram_en_o = issue_s;
    if (issue_s) begin
      ram_addr_o = addr_q;
    end else begin
      ram_addr_o = ram_addr_q;
    end
  end

  // Address, length and beat bookkeeping.
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    beat_d      = beat_q;
    ram_addr_d  = ram_addr_q;
    inflight_d  = issue_s;
    zero_done_d = cmd_fire_s && (cmd_len_i == LEN_ZERO);
    if (cmd_fire_s) begin
      addr_d = cmd_addr_i & ALIGN_MASK;
      rem_d  = cmd_len_i;
      len_d  = cmd_len_i;
      beat_d = LEN_ZERO;
    end else begin
      if (issue_s) begin
        addr_d     = addr_q + ADDR_STEP;
        rem_d      = rem_q - LEN_ONE;
        ram_addr_d = addr_q;
      end else begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        ram_addr_d = ram_addr_q;
      end
      if (pop_s) begin
        beat_d = beat_q + LEN_ONE;
      end else begin
        beat_d = beat_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= {ADDR_WIDTH{1'b0}};
      ram_addr_q  <= {ADDR_WIDTH{1'b0}};
      rem_q       <= LEN_ZERO;
      len_q       <= LEN_ZERO;
      beat_q      <= LEN_ZERO;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Two-entry buffer: RAM data is captured only in the cycle after an issue.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    if (inflight_q) begin
      buf_d[wr_ptr_q] = ram_rdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = occ_s[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q[0] <= {DATA_WIDTH{1'b0}};
      buf_q[1] <= {DATA_WIDTH{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Scoreboard bench for sp_ram_burst_reader with a behavioural RAM and randomized bursts.
module tb_sp_ram_burst_reader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            done;
  logic            busy;
  logic            ram_en;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [DW/8-1:0] ram_be;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;

  logic [DW-1:0]   mem [0:63];

  int total = 0;
  int bad   = 0;
  int issued = 0;
  int popped = 0;
  int beats_total = 0;
  int ready_mode = 0;
  int pat_idx = 0;
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  beat_t         exp_q [$];
  logic [AW-1:0] exp_addr [$];
  bit            zero_next = 1'b0;
  bit            stalled = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  bit            mon_pop;
  logic          mon_done;
  beat_t         mon_b;

  sp_ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (done),
    .busy_o      (busy),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM drives rdata every cycle; garbage when the previous cycle had no read.
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr[7:2]];
    else        ram_rdata <= $urandom();
  end

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat[pat_idx] != 0);
        pat_idx = (pat_idx + 1) % 6;
      end
      2: out_ready = ($urandom_range(0, 1) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor / scoreboard: expectations are pushed when a command handshake is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr.delete();
      issued = 0;
      popped = 0;
      zero_next = 1'b0;
      stalled = 1'b0;
    end else begin
      chk("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
      if (ram_en) begin
        chk("ram_we", 64'(ram_we), 64'(0));
        chk("ram_be", 64'(ram_be), 64'(4'hF));
        chk("ram_wdata", 64'(ram_wdata), 64'(0));
        if (exp_addr.size() == 0) fail_now("unexpected_ram_en");
        else chk("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
        issued++;
      end
      mon_pop = out_valid && out_ready;
      if (out_valid && stalled) begin
        chk("stall_data", 64'(out_data), 64'(held_data));
        chk("stall_last", 64'(out_last), 64'(held_last));
      end
      mon_done = zero_next;
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          mon_b = exp_q.pop_front();
          chk("beat_data", 64'(out_data), 64'(mon_b.data));
          chk("beat_last", 64'(out_last), 64'(mon_b.last));
          if (mon_b.last) mon_done = 1'b1;
        end
        popped++;
        beats_total++;
      end
      chk("done", 64'(done), 64'(mon_done));
      chk("outstanding_le2", 64'((issued - popped) <= 2), 64'(1));
      zero_next = cmd_valid && cmd_ready && (cmd_len == 8'd0);
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i < int'(cmd_len); i++) begin
          int w;
          beat_t b;
          w = ((int'(cmd_addr) / 4) * 4 + 4 * i) % 256;
          exp_addr.push_back(AW'(w));
          b.data = mem[w / 4];
          b.last = (i == int'(cmd_len) - 1);
          exp_q.push_back(b);
        end
      end
      stalled = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("idle_timeout");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_last"},  64'(out_last),  64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_ram_en"},    64'(ram_en),    64'(0));
    chk({tag, "_ram_addr"},  64'(ram_addr),  64'(0));
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    mem[4] = 32'hA000_00A0;
    mem[5] = 32'hA000_00A1;
    mem[6] = 32'hA000_00A2;
    mem[7] = 32'hA000_00A3;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    // Full-throughput burst with latency measured from the first read cycle.
    ready_mode = 0;
    send_cmd(8'h10, 8'd4);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done) break;
      cyc++;
    end
    chk("burst4_done_cycles", 64'(cyc), 64'(5));
    wait_idle();

    // Same burst under the 1,0,0,1,0,1 backpressure pattern.
    ready_mode = 1;
    send_cmd(8'h10, 8'd4);
    wait_idle();

    ready_mode = 0;
    send_cmd(8'hF8, 8'd4);
    wait_idle();
    send_cmd(8'h13, 8'd1);
    wait_idle();

    // Empty burst: done the next cycle, no RAM traffic.
    send_cmd(8'h20, 8'd0);
    @(negedge clk);
    chk("len0_done", 64'(done), 64'(1));
    chk("len0_busy", 64'(busy), 64'(1));
    chk("len0_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    chk("len0_done_clear", 64'(done), 64'(0));
    chk("len0_ready_back", 64'(cmd_ready), 64'(1));
    wait_idle();

    ready_mode = 2;
    for (int k = 0; k < 25; k++) begin
      send_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 12)));
      if ($urandom_range(0, 1) != 0) wait_idle();
    end
    wait_idle();

    // Reset in the middle of a 16-word burst with another command held.
    ready_mode = 0;
    base = beats_total;
    send_cmd(8'h40, 8'd16);
    cyc = 0;
    while (beats_total < base + 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (beats_total < base + 5) fail_now("mid_burst_beats_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = 8'h80;
    cmd_len = 8'd3;
    ready_mode = 3;
    @(posedge clk);
    #1;
    chk("held_cmd_not_ready", 64'(cmd_ready), 64'(0));
    chk("held_cmd_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst1");
    @(posedge clk);
    #1;
    check_reset_vals("midrst2");
    rst_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
